// File: rtl/ps2_frame_gen.sv
// PS/2 device-side frame generator: FIFO-buffered bytes serialised as start, 8 data LSB-first, odd parity, stop.
// Define PS2_MAKE_BREAK_EN to send each popped byte as the triple B, 0xF0, B.
module ps2_frame_gen #(
    parameter int CLK_DIV  = 16,
    parameter int FIFO_AW  = 3,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       frame_done,
    output logic       ps2_clk,
    output logic       ps2_data
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int DEPTH    = 2**FIFO_AW;
    localparam int GAP_CYC  = GAP_BITS * 2 * CLK_DIV;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int CNT_MAX  = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int DIV_W    = $clog2(CNT_MAX + 1);

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0] r_cnt;
    logic             r_ovf;
    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit;
    logic [10:0]      r_sh;
    logic             r_clk, r_data, r_frame_done, r_pend;
    logic             w_pop, w_push, w_div_end, w_gap_end, w_last_bit, w_more;

    // Occupancy can only reach DEPTH, so its top bit alone flags full.
    assign full       = r_cnt[FIFO_AW];
    assign empty      = (r_cnt == '0);
    assign w_pop      = (r_state == S_IDLE) && !empty;
    assign w_push     = wr_en && (!full || w_pop);
    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_gap_end  = (r_div == DIV_W'(GAP_LAST));
    assign w_last_bit = (r_bit == 4'd10);

    assign busy       = (r_state != S_IDLE);
    assign ovf        = r_ovf;
    assign frame_done = r_frame_done;
    assign ps2_clk    = r_clk;
    assign ps2_data   = r_data;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
            if (wr_en && !w_push) r_ovf <= 1'b1;
        end
    end

`ifdef PS2_MAKE_BREAK_EN
    logic [1:0] r_sub;
    logic [7:0] r_byte;
    logic [7:0] w_next;
    assign w_more = (r_sub != 2'd2);
    assign w_next = (r_sub == 2'd0) ? 8'hF0 : r_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub  <= 2'd0;
            r_byte <= 8'h00;
        end else if (w_pop) begin
            r_sub  <= 2'd0;
            r_byte <= r_mem[r_rptr];
        end else if (r_state == S_LOW && w_div_end && w_last_bit && w_more) begin
            r_sub  <= r_sub + 2'd1;
        end
    end
`else
    assign w_more = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= 4'd0;
            r_sh         <= '1;
            r_clk        <= 1'b1;
            r_data       <= 1'b1;
            r_frame_done <= 1'b0;
            r_pend       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sh    <= frame_of(r_mem[r_rptr]);
                        r_bit   <= 4'd0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_data  <= r_sh[0];
                    r_clk   <= 1'b1;
                    r_div   <= '0;
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_clk   <= 1'b0;
                        r_state <= S_LOW;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LOW: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        r_clk <= 1'b1;
                        if (w_last_bit) begin
                            r_frame_done <= 1'b1;
                            r_data       <= 1'b1;
                            r_pend       <= w_more;
                            r_bit        <= 4'd0;
`ifdef PS2_MAKE_BREAK_EN
                            if (w_more) r_sh <= frame_of(w_next);
`endif
                            if (GAP_BITS > 0) r_state <= S_GAP;
                            else if (w_more)  r_state <= S_LOAD;
                            else              r_state <= S_IDLE;
                        end else begin
                            // Next bit is presented as the clock rises, ahead of the next falling edge.
                            r_sh    <= r_sh >> 1;
                            r_data  <= r_sh[1];
                            r_bit   <= r_bit + 4'd1;
                            r_state <= S_HIGH;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_div   <= '0;
                        r_state <= r_pend ? S_LOAD : S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_frame_gen.sv
// Bench for ps2_frame_gen: a line-level decoder captures frames, compared with a byte-level frame model.
module tb_ps2_frame_gen;
    localparam int CLK_DIV  = 4;
    localparam int FIFO_AW  = 2;
    localparam int GAP_BITS = 2;
    localparam int GAP_CYC  = 2 * GAP_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       full, empty, busy, ovf, frame_done, ps2_clk, ps2_data;

    int checks = 0;
    int errors = 0;

    logic [10:0] rx_q[$];
    logic [10:0] exp_q[$];
    int          start_q[$];
    int          fd_cnt = 0;
    int          fd_bad = 0;
    int          cyc = 0;
    int          mon_bits = 0;

    ps2_frame_gen #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .busy(busy), .ovf(ovf), .frame_done(frame_done),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;

    // Reference: a frame is start 0, data LSB first, a bit making the 1-count odd, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic push_expect(input logic [7:0] b);
        exp_q.push_back(model_frame(b));
`ifdef PS2_MAKE_BREAK_EN
        exp_q.push_back(model_frame(8'hF0));
        exp_q.push_back(model_frame(b));
`endif
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
        fd_cnt = 0;
    endtask

    // Line decoder: samples just after each rising edge of clk.
    initial begin
        logic [10:0] cur;
        logic prev_clk, prev_data, prev_fd, after_stop;
        cur = '0; prev_clk = 1'b1; prev_data = 1'b1; prev_fd = 1'b0; after_stop = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                mon_bits = 0; prev_clk = 1'b1; prev_data = 1'b1; prev_fd = 1'b0; after_stop = 1'b0;
            end else begin
                if (prev_data && !ps2_data && ps2_clk && mon_bits == 0) start_q.push_back(cyc);
                if (prev_clk && !ps2_clk) begin
                    cur[mon_bits] = ps2_data;
                    mon_bits++;
                    after_stop = 1'b0;
                    if (mon_bits == 11) begin
                        rx_q.push_back(cur);
                        mon_bits = 0;
                        after_stop = 1'b1;
                    end
                end
                if (frame_done) begin
                    fd_cnt++;
                    if (!(after_stop && !prev_clk && ps2_clk) || prev_fd) fd_bad++;
                    after_stop = 1'b0;
                end
                prev_clk = ps2_clk; prev_data = ps2_data; prev_fd = frame_done;
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(posedge clk); #1;
            n++;
            quiet = (!busy && empty) ? quiet + 1 : 0;
        end
        if (quiet < 4) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ps2_clk, ps2_data, full, empty, busy, ovf, frame_done} !== 7'b1101000) begin
            errors++;
            $display("FAIL reset_outputs: clk,data,full,empty,busy,ovf,fd = %b, required 1101000",
                     {ps2_clk, ps2_data, full, empty, busy, ovf, frame_done});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ps2_clk !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%b ps2_clk=%b, required 0/1", busy, ps2_clk);
        end
    endtask

    task automatic test_latency_0x79();
        logic dv [0:15];
        logic cv [0:15];
        logic bv [0:15];
        clear_logs();
        wr_data = 8'h79; wr_en = 1'b1;
        push_expect(8'h79);
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL push_state: empty=%b busy=%b, required 0/0", empty, busy);
        end
        for (int j = 1; j <= 2 + CLK_DIV; j++) begin
            @(posedge clk); #1;
            dv[j] = ps2_data; cv[j] = ps2_clk; bv[j] = busy;
        end
        checks++;
        if (dv[1] !== 1'b1 || dv[2] !== 1'b0) begin
            errors++;
            $display("FAIL start_latency: data at N+2=%b N+3=%b, required 1/0", dv[1], dv[2]);
        end
        checks++;
        if (cv[1+CLK_DIV] !== 1'b1 || cv[2+CLK_DIV] !== 1'b0) begin
            errors++;
            $display("FAIL clk_latency: clk at N+2+DIV=%b N+3+DIV=%b, required 1/0",
                     cv[1+CLK_DIV], cv[2+CLK_DIV]);
        end
        checks++;
        if (bv[1] !== 1'b1) begin
            errors++;
            $display("FAIL busy_load: busy=%b, required 1", bv[1]);
        end
        wait_idle(2000, "lat");
        checks++;
        if (rx_q.size() < 1 || rx_q[0] !== 11'b100_1111_0010) begin
            errors++;
            $display("FAIL frame_0x79: got %b (n=%0d), required 10011110010", rx_q.size() ? rx_q[0] : 11'bx, rx_q.size());
        end
        checks++;
        if (rx_q.size() != exp_q.size() || fd_cnt != exp_q.size() || fd_bad != 0) begin
            errors++;
            $display("FAIL count_0x79: frames=%0d done=%0d bad_done=%0d, required %0d/%0d/0",
                     rx_q.size(), fd_cnt, fd_bad, exp_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        wr_en = 1'b1;
        wr_data = 8'h5A; push_expect(8'h5A);
        @(posedge clk); #1;
        wr_data = 8'h74; push_expect(8'h74);
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_idle(3000, "b2b");
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: frames=%0d, required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %b, required %b", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_q.size() < 1 || rx_q[0][9] !== 1'b1) begin
            errors++;
            $display("FAIL parity_0x5A: got %b, required 1", rx_q.size() ? rx_q[0][9] : 1'bx);
        end
        checks++;
        if (start_q.size() < 2 ||
`ifdef PS2_MAKE_BREAK_EN
            start_q[1] - start_q[0] != 22 * CLK_DIV + GAP_CYC + 1) begin
`else
            start_q[1] - start_q[0] != 22 * CLK_DIV + GAP_CYC + 2) begin
`endif
            errors++;
            $display("FAIL b2b_period: start spacing %0d (n=%0d), required frame+gap period",
                     start_q.size() >= 2 ? start_q[1] - start_q[0] : -1, start_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [0:5];
        clear_logs();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) push_expect(b[i]);
        for (int i = 0; i < 6; i++) begin
            wr_data = b[i]; wr_en = 1'b1;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags: full=%b ovf=%b, required 1/1", full, ovf);
        end
        wait_idle(6000, "ovf");
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_count: frames=%0d, required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %b, required %b", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", ovf);
        end
    endtask

    task automatic test_midframe_reset();
        int n = 0;
        clear_logs();
        wr_en = 1'b1; wr_data = 8'h7B;
        @(posedge clk); #1;
        wr_data = 8'h33;
        @(posedge clk); #1;
        wr_en = 1'b0;
        while (mon_bits != 5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mon_bits != 5) begin
            errors++;
            $display("FAIL mid_reach: bits seen=%0d, required 5", mon_bits);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ps2_clk, ps2_data, empty, busy, ovf, full} !== 6'b111000) begin
            errors++;
            $display("FAIL mid_reset: clk,data,empty,busy,ovf,full=%b, required 111000",
                     {ps2_clk, ps2_data, empty, busy, ovf, full});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        wr_data = 8'h7D; wr_en = 1'b1; push_expect(8'h7D);
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_idle(2000, "mid");
        checks++;
        if (rx_q.size() != exp_q.size() || rx_q.size() == 0 || rx_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL mid_resend: n=%0d first=%b, required n=%0d first=%b",
                     rx_q.size(), rx_q.size() ? rx_q[0] : 11'bx, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int nb;
            clear_logs();
            nb = $urandom_range(4, 1);
            for (int k = 0; k < nb; k++) begin
                logic [7:0] v;
                v = 8'($urandom);
                wr_data = v; wr_en = 1'b1; push_expect(v);
                @(posedge clk); #1;
                wr_en = 1'b0;
                repeat ($urandom_range(2, 0)) @(posedge clk);
                #1;
            end
            wait_idle(8000, "rand");
            checks++;
            if (rx_q.size() != exp_q.size() || fd_cnt != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: frames=%0d done=%0d, required %0d", r, rx_q.size(), fd_cnt, exp_q.size());
            end
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_frame%0d: got %b, required %b", r, i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ovf !== 1'b0 || fd_bad != 0) begin
            errors++;
            $display("FAIL rand_flags: ovf=%b bad_done=%0d, required 0/0", ovf, fd_bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency_0x79();
        test_back_to_back();
        test_overflow();
        test_midframe_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_frame_gen.md
Name: ps2_frame_gen

Overview:
Synthesizable PS/2 device-side frame generator: the parametrised successor of the hand-coded PS/2 bit stimulus used on the calculator top level. Buffers scan-code bytes in an internal FIFO and serialises each as an 11-bit PS/2 frame: start, 8 data LSB-first, computed odd parity, stop. Clock rate and inter-frame gap are parametrised. Drives ps2_clk/ps2_data of the calculator's keyboard input in benches and FPGA self-test builds.

Parameters:
CLK_DIV, 16, system clk cycles per PS/2 half-period (>=2)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW bytes
GAP_BITS, 2, idle PS/2 periods inserted after every frame (>=0)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous, active-low
wr_data  in  8  scan code to queue
wr_en  in  1  push wr_data when high
full  out  1  FIFO holds 2**FIFO_AW bytes
empty  out  1  FIFO holds 0 bytes
busy  out  1  frame or gap in progress
ovf  out  1  sticky: push attempted while full
frame_done  out  1  one-cycle pulse after each stop bit completes
ps2_clk  out  1  PS/2 clock, idle high
ps2_data  out  1  PS/2 data, idle high

Behaviour:
- Reset (async, rst_n low): FIFO emptied, FSM IDLE, divider 0; ps2_clk=1, ps2_data=1, full=0, empty=1, busy=0, ovf=0, frame_done=0.
- FIFO: push on wr_en && !full; wr_en && full drops the byte and sets ovf (cleared only by reset). Simultaneous push and pop when full: pop frees the slot, push accepted, full stays 1. Pointers wrap modulo 2**FIFO_AW; occupancy counter FIFO_AW+1 bits wide.
- FSM states: IDLE, LOAD, HIGH, LOW, GAP.
- IDLE: when !empty, pop into 11-bit shift reg {1, ^byte~, byte, 0} (parity = ~^byte), bit counter 0, go LOAD.
- LOAD: one cycle; busy=1; go HIGH.
- HIGH: ps2_data = current bit (updated on entry), ps2_clk=1 for CLK_DIV cycles; go LOW.
- LOW: ps2_clk=0 for CLK_DIV cycles (receiver samples on falling edge); ps2_data unchanged. On exit: if bit counter==10, pulse frame_done, go GAP (or IDLE if GAP_BITS==0); else shift, increment counter, go HIGH.
- GAP: ps2_clk=1, ps2_data=1 for GAP_BITS*2*CLK_DIV cycles; go IDLE.
- Latency: byte pushed at cycle N into empty FIFO with FSM IDLE -> ps2_data falls (start bit) at cycle N+3 (pop N+1, LOAD N+2, HIGH N+3); first ps2_clk fall at N+3+CLK_DIV.
- Frame length: 22*CLK_DIV cycles in HIGH/LOW plus one LOAD cycle; back-to-back frames add 2*GAP_BITS*CLK_DIV + 1 IDLE cycle.
- busy=1 in LOAD/HIGH/LOW/GAP. Pushes are accepted in every state.
- rst_n asserted mid-frame: lines return high immediately; a partial frame is never resumed.

Optional Feature:
PS2_MAKE_BREAK_EN: when defined, each popped byte B is sent as three frames: B, 0xF0, B (key press plus release), with a GAP between frames; frame_done pulses after each frame. The FIFO is popped once per triple. When undefined, one frame per popped byte.

Test Plan:
Push 0x79, CLK_DIV=4 -> on the 11 ps2_clk falls, ps2_data = 0,1,0,0,1,1,1,1,0,0,1 (parity 0); frame_done one cycle after the 11th low phase.
Push 0x5A then 0x74 back-to-back -> 0x5A parity 1, 0x74 parity 1; 2*GAP_BITS*CLK_DIV high-idle cycles between the stop bit and the next start.
FIFO_AW=2, 6 pushes on consecutive cycles while IDLE -> 5 bytes accepted (one popped to shift reg), full=1, ovf=1, exactly 5 frames emitted in order.
rst_n low during data bit 4 of 0x7B -> ps2_clk=ps2_data=1 asynchronously, empty=1; after release a new push of 0x7D is sent intact.
PS2_MAKE_BREAK_EN defined, push 0x75 -> frames 0x75, 0xF0, 0x75; three frame_done pulses; empty=1 after the first pop.
Push at cycle N with FSM IDLE -> ps2_data low exactly at N+3, ps2_clk low at N+3+CLK_DIV.
